// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master round-robin arbiter in front of the single data_ram port.
// Master 0 is the I-side engine and master 1 is the D-side engine.
// The grant is held across a multi-beat burst. After BURST acks the owner is forced
// to hand over, but only if the other master is waiting. One dead cycle (S_GAP)
// always separates two owners on the RAM.
// Optional feature macro: ARB_WDOG_EN adds a stall watchdog that aborts a tenure
// after WDOG_CYCLES cycles with ram_cs high and no ram_ack.
module ram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BURST       = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  // master 0 (I-side)
  input  logic              m0_req,
  input  logic              m0_cs,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_din,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_dout,
  // master 1 (D-side)
  input  logic              m1_req,
  input  logic              m1_cs,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_din,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_dout,
  // data_ram port
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_ack,
  // status
  output logic              busy,
  output logic              wdog_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNT0 = 2'd1;
  localparam logic [1:0] S_GNT1 = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int CNT_W = $clog2(BURST + 1);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;        // id of the most recent owner
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             wdog_err_q, wdog_err_d;

  logic             in_gnt;
  logic             own_id;
  logic             own_req;
  logic             oth_req;
  logic [CNT_W-1:0] beat_next;
  logic             burst_done;
  logic             wdog_abort;

  assign in_gnt     = (state_q == S_GNT0) || (state_q == S_GNT1);
  assign own_id     = (state_q == S_GNT1);
  assign own_req    = own_id ? m1_req : m0_req;
  assign oth_req    = own_id ? m0_req : m1_req;
  assign beat_next  = beat_cnt_q + CNT_W'(ram_ack);
  assign burst_done = (beat_next == CNT_W'(BURST));

  // Grants come straight from the state flops, so they are registered and drop
  // asynchronously with reset.
  assign m0_gnt   = (state_q == S_GNT0);
  assign m1_gnt   = (state_q == S_GNT1);
  assign busy     = (state_q != S_IDLE);
  assign m0_dout  = ram_dout;
  assign m1_dout  = ram_dout;
  assign wdog_err = wdog_err_q;

`ifdef ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

  // The stall counter runs only while the owner strobes ram_cs without an ack.
  always_comb begin
    wdog_cnt_d = '0;
    if (in_gnt && !ram_ack) begin
      wdog_cnt_d = ram_cs ? wdog_cnt_q + WDOG_W'(1) : wdog_cnt_q;
    end
  end

  assign wdog_abort = in_gnt && ram_cs && !ram_ack &&
                      (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

  // Register for the stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_cnt_q <= '0;
    else        wdog_cnt_q <= wdog_cnt_d;
  end
`else
  assign wdog_abort = 1'b0;
`endif

  // Route the owner's strobes to the RAM. Outside a grant the RAM sees zeros and
  // stray acks are swallowed.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state_q)
      S_GNT0: begin
        ram_cs   = m0_cs;
        ram_we   = m0_we;
        ram_addr = m0_addr;
        ram_din  = m0_din;
        m0_ack   = ram_ack;
      end
      S_GNT1: begin
        ram_cs   = m1_cs;
        ram_we   = m1_we;
        ram_addr = m1_addr;
        ram_din  = m1_din;
        m1_ack   = ram_ack;
      end
      default: ;
    endcase
  end

  // Arbitration FSM: round-robin pick, hold for the burst, forced hand-over and gap.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    wdog_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m0_req && m1_req) state_d = last_q ? S_GNT0 : S_GNT1;
        else if (m0_req)      state_d = S_GNT0;
        else if (m1_req)      state_d = S_GNT1;
      end
      S_GNT0, S_GNT1: begin
        beat_cnt_d = beat_next;
        if (!own_req || wdog_abort || (burst_done && oth_req)) begin
          // The ack that completes the burst has already been routed this cycle.
          state_d    = S_GAP;
          last_d     = own_id;
          beat_cnt_d = '0;
          wdog_err_d = wdog_abort;
        end else if (burst_done) begin
          // Nobody is waiting, so start a fresh fairness window without a gap.
          beat_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;  // S_GAP: exactly one dead cycle
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      beat_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter. The expected values are worked out by hand
// from the arbitration rules. Inputs change 2 ns after a rising edge. Outputs are
// read after that point, once the combinational paths have settled.
module tb_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_cs, m0_we, m0_gnt, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_din, m0_dout;
  logic          m1_req, m1_cs, m1_we, m1_gnt, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_din, m1_dout;
  logic          ram_cs, ram_we, ram_ack;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy, wdog_err;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST(4), .WDOG_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_cs(m0_cs), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_cs(m1_cs), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_dout(m1_dout),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_ack(ram_ack),
    .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_cs = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_din = '0;
    m1_req = 1'b0; m1_cs = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_din = '0;
    ram_ack = 1'b0; ram_dout = 32'hD00D_0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  logic seen_err, lost_gnt;

  initial begin
    idle_inputs();
    // ---- reset state; a request and strobe present during reset are ignored ----
    m0_req = 1'b1;
    m0_cs  = 1'b1;
    cyc();
    settle();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_wdog_err", wdog_err, 0);
    idle_inputs();
    rst_n = 1'b1;
    cyc();

    // ---- t1: m0 alone, 4 writes acked 2 cycles apart ----
    m0_req = 1'b1;
    settle();
    check("t1_gnt_latency", m0_gnt, 0);
    cyc();
    check("t1_m0_gnt", m0_gnt, 1);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      m0_cs = 1'b1; m0_we = 1'b1;
      m0_addr = 32'h100 + 32'(i * 4);
      m0_din  = 32'hA0 + 32'(i);
      settle();
      check("t1_ram_cs", ram_cs, 1);
      check("t1_ram_we", ram_we, 1);
      check("t1_ram_addr", ram_addr, 32'h100 + 32'(i * 4));
      check("t1_ram_din", ram_din, 32'hA0 + 32'(i));
      check("t1_m0_ack_idle", m0_ack, 0);
      cyc();
      ram_ack = 1'b1;
      ram_dout = 32'hD0 + 32'(i);
      settle();
      check("t1_m0_ack", m0_ack, 1);
      check("t1_m1_ack", m1_ack, 0);
      check("t1_m0_dout", m0_dout, 32'hD0 + 32'(i));
      cyc();
      ram_ack = 1'b0;
    end
    check("t1_gnt_after_burst", m0_gnt, 1);
    m0_req = 1'b0; m0_cs = 1'b0; m0_we = 1'b0;
    cyc();
    // In S_GAP: a strobe and a stray ack must not reach either side.
    m0_cs = 1'b1; ram_ack = 1'b1;
    settle();
    check("t1_gap_gnt", m0_gnt, 0);
    check("t1_gap_ram_cs", ram_cs, 0);
    check("t1_gap_ram_addr", ram_addr, 0);
    check("t1_gap_m0_ack", m0_ack, 0);
    check("t1_gap_busy", busy, 1);
    cyc();
    ram_ack = 1'b0; m0_cs = 1'b0;
    check("t1_idle_busy", busy, 0);

    // ---- t2: simultaneous requests after reset, round-robin order ----
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    cyc();
    check("t2_first_m0", m0_gnt, 1);
    check("t2_first_m1", m1_gnt, 0);
    m0_req = 1'b0;
    cyc();
    check("t2_gap_m0", m0_gnt, 0);
    check("t2_gap_m1", m1_gnt, 0);
    cyc();
    check("t2_idle_m1", m1_gnt, 0);
    cyc();
    check("t2_second_m1", m1_gnt, 1);
    m0_req = 1'b1; m1_req = 1'b0;
    cyc(); cyc(); cyc();
    check("t2_third_m0", m0_gnt, 1);
    check("t2_third_m1", m1_gnt, 0);
    m0_req = 1'b0;
    cyc();
    m0_req = 1'b1; m1_req = 1'b1;
    cyc(); cyc();
    check("t2_tie_m1", m1_gnt, 1);
    check("t2_tie_m0", m0_gnt, 0);
    m1_req = 1'b0;
    cyc(); cyc(); cyc();
    check("t2_tie_back_m0", m0_gnt, 1);
    m0_req = 1'b0;
    cyc(); cyc();

    // ---- t3: m0 wants 8 beats, m1 waiting -> forced hand-over after 4 ----
    m0_req = 1'b1;
    cyc();
    check("t3_m0_gnt", m0_gnt, 1);
    m1_req = 1'b1; m0_cs = 1'b1; ram_ack = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      settle();
      check("t3_m0_ack", m0_ack, 1);
      cyc();
      check("t3_m0_gnt_beat", m0_gnt, (b < 4) ? 1 : 0);
    end
    settle();
    check("t3_gap_m0_ack", m0_ack, 0);
    check("t3_gap_m1_ack", m1_ack, 0);
    check("t3_gap_ram_cs", ram_cs, 0);
    check("t3_gap_m1_gnt", m1_gnt, 0);
    cyc();
    ram_ack = 1'b0;
    cyc();
    check("t3_m1_gnt", m1_gnt, 1);
    check("t3_m0_out", m0_gnt, 0);
    m1_cs = 1'b1; ram_ack = 1'b1;
    settle();
    check("t3_m1_ack", m1_ack, 1);
    check("t3_m0_no_ack", m0_ack, 0);
    cyc();
    ram_ack = 1'b0; m1_cs = 1'b0; m1_req = 1'b0;
    cyc(); cyc(); cyc();
    check("t3_m0_regrant", m0_gnt, 1);
    ram_ack = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      settle();
      check("t3_rest_ack", m0_ack, 1);
      cyc();
      check("t3_rest_gnt", m0_gnt, 1);
    end
    ram_ack = 1'b0; m0_req = 1'b0; m0_cs = 1'b0;
    cyc(); cyc();

    // ---- t4: m0 8 beats with m1 idle -> grant never drops ----
    m0_req = 1'b1;
    cyc();
    m0_cs = 1'b1; ram_ack = 1'b1;
    for (int b = 1; b <= 8; b++) begin
      cyc();
      check("t4_m0_gnt", m0_gnt, 1);
    end
    check("t4_busy", busy, 1);
    ram_ack = 1'b0; m0_req = 1'b0; m0_cs = 1'b0;
    cyc(); cyc();

    // ---- t5: reset mid-burst ----
    m0_req = 1'b1;
    cyc();
    m0_cs = 1'b1; ram_ack = 1'b1;
    cyc(); cyc();
    ram_ack = 1'b0;
    rst_n = 1'b0;
    settle();
    check("t5_rst_m0_gnt", m0_gnt, 0);
    check("t5_rst_ram_cs", ram_cs, 0);
    check("t5_rst_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    m0_req = 1'b0; m0_cs = 1'b0; m1_req = 1'b1;
    cyc();
    check("t5_m1_gnt", m1_gnt, 1);

    // ---- t6: m1 stalls with ram_cs high and no ack ----
    m1_cs = 1'b1;
    seen_err = 1'b0;
    lost_gnt = 1'b0;
`ifdef ARB_WDOG_EN
    for (int c = 1; c <= 63; c++) begin
      cyc();
      seen_err = seen_err | wdog_err;
      lost_gnt = lost_gnt | ~m1_gnt;
    end
    check("t6_no_early_err", seen_err, 0);
    check("t6_no_early_drop", lost_gnt, 0);
    cyc();
    check("t6_wdog_err", wdog_err, 1);
    check("t6_m1_gnt_drop", m1_gnt, 0);
    check("t6_busy_gap", busy, 1);
    m1_req = 1'b0; m1_cs = 1'b0;
    cyc();
    check("t6_wdog_pulse_end", wdog_err, 0);
    check("t6_busy_clear", busy, 0);
`else
    for (int c = 1; c <= 70; c++) begin
      cyc();
      seen_err = seen_err | wdog_err;
      lost_gnt = lost_gnt | ~m1_gnt;
    end
    check("t6_wdog_err_tied", seen_err, 0);
    check("t6_gnt_held", lost_gnt, 0);
    m1_req = 1'b0; m1_cs = 1'b0;
    cyc(); cyc();
    check("t6_busy_clear", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
